// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and address check for the data memory arbiter
//
// Purpose : common definitions imported by dmem_arbiter and dmem_arb_pick.
// Contents: MEM_BYTES, sequencer state enum, port-id constants and the
//           address-legality helper.
package dmem_pkg;

   localparam int MEM_BYTES = 128;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbState_t;

   // A word access touches addr and addr+1, so the last legal word starts at
   // MEM_BYTES-2 and odd addresses are never allowed.
   function automatic logic addrIllegal(input logic [15:0] addr);
      return addr[0] | (addr > 16'(MEM_BYTES - 2));
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational winner selection between the two memory requesters
//
// Purpose : decides which port is served when the sequencer is idle.
// Macro   : DMEM_ARB_RR_EN - defined: ties go to the port that was not served
//           last (round-robin); undefined: ties always go to port 0.
// Ports   : Req0, Req1  request lines of port 0 (CPU) and port 1 (debug/DMA)
//           Last        port id of the most recently completed access
//           Win         at least one port is requesting
//           WinPort     id of the winning port (meaningful when Win=1)
module dmem_arb_pick
   import dmem_pkg::*;
(
   input  logic Req0,
   input  logic Req1,
   input  logic Last,
   output logic Win,
   output logic WinPort
);

`ifdef DMEM_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   always_comb begin
      Win     = Req0 | Req1;
      WinPort = PORT_CPU;
      if (Req0 && Req1) begin
         WinPort = RR_EN ? ~Last : PORT_CPU;
      end else if (Req1) begin
         WinPort = PORT_DBG;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and IDLE/ACCESS/RESP sequencer for the 128-byte data memory
//
// Purpose : shares the single data memory port between the CPU load/store
//           unit (port 0) and the debug/DMA master (port 1). Every access takes
//           IDLE -> ACCESS -> RESP; illegal addresses are answered with Err and
//           never reach the memory.
// Macro   : DMEM_ARB_RR_EN - round-robin tie breaking (see dmem_arb_pick).
// Ports   : Clock, Reset              clock, synchronous active-high reset
//           Req/We/Addr/WData[0,1]    request and its fields, held until Gnt
//           Gnt[0,1]                  one-cycle grant, high in the ACCESS cycle
//           Valid/Err/RData[0,1]      one-cycle completion, high in RESP
//           MemAddress/MemWriteData   memory address / write data (0 outside ACCESS)
//           MemWrite/MemRead          memory strobes (ACCESS only, legal only)
//           MemReadData               combinational read data from memory
module dmem_arbiter
   import dmem_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        We0,
   input  logic        We1,
   input  logic [15:0] Addr0,
   input  logic [15:0] Addr1,
   input  logic [15:0] WData0,
   input  logic [15:0] WData1,
   output logic        Gnt0,
   output logic        Gnt1,
   output logic        Valid0,
   output logic        Valid1,
   output logic        Err0,
   output logic        Err1,
   output logic [15:0] RData0,
   output logic [15:0] RData1,
   output logic [15:0] MemAddress,
   output logic [15:0] MemWriteData,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [15:0] MemReadData
);

   arbState_t   state;
   arbState_t   nextState;
   logic        cur;
   logic        last;
   logic        capWe;
   logic        errFlag;
   logic [15:0] capAddr;
   logic [15:0] capWData;
   logic [15:0] respData;

   logic        win;
   logic        winPort;
   logic        selWe;
   logic [15:0] selAddr;
   logic [15:0] selWData;

   dmem_arb_pick uPick (
      .Req0    (Req0),
      .Req1    (Req1),
      .Last    (last),
      .Win     (win),
      .WinPort (winPort)
   );

   assign selWe    = (winPort == PORT_DBG) ? We1    : We0;
   assign selAddr  = (winPort == PORT_DBG) ? Addr1  : Addr0;
   assign selWData = (winPort == PORT_DBG) ? WData1 : WData0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         cur      <= PORT_CPU;
         last     <= PORT_DBG;
         capWe    <= 1'b0;
         errFlag  <= 1'b0;
         capAddr  <= '0;
         capWData <= '0;
         respData <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (win) begin
                  cur      <= winPort;
                  capWe    <= selWe;
                  capAddr  <= selAddr;
                  capWData <= selWData;
                  errFlag  <= addrIllegal(selAddr);
               end
            end
            ACCESS: begin
               // Writes and rejected accesses return zero so RData never
               // carries stale memory contents.
               respData <= (capWe | errFlag) ? 16'h0000 : MemReadData;
            end
            RESP: begin
               last <= cur;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      nextState    = state;
      Gnt0         = 1'b0;
      Gnt1         = 1'b0;
      Valid0       = 1'b0;
      Valid1       = 1'b0;
      Err0         = 1'b0;
      Err1         = 1'b0;
      RData0       = '0;
      RData1       = '0;
      MemAddress   = '0;
      MemWriteData = '0;
      MemWrite     = 1'b0;
      MemRead      = 1'b0;

      case (state)
         IDLE: begin
            if (win) begin
               nextState = ACCESS;
            end
         end
         ACCESS: begin
            Gnt0         = (cur == PORT_CPU);
            Gnt1         = (cur == PORT_DBG);
            MemAddress   = capAddr;
            MemWriteData = capWData;
            // Reset gates the write combinationally so an access aborted in
            // this cycle cannot commit half-way at the closing edge.
            MemWrite     = capWe & ~errFlag & ~Reset;
            MemRead      = ~capWe & ~errFlag;
            nextState    = RESP;
         end
         RESP: begin
            if (cur == PORT_DBG) begin
               Valid1 = 1'b1;
               Err1   = errFlag;
               RData1 = respData;
            end else begin
               Valid0 = 1'b1;
               Err0   = errFlag;
               RData0 = respData;
            end
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 128-byte, big-endian, byte-addressed data memory. It shares the single memory port between the CPU load/store unit (port 0) and a debug/DMA master (port 1). Each access runs through a fixed IDLE→ACCESS→RESP sequence, and illegal addresses are rejected before they reach memory. It sits between the core's MEM stage and the data memory instance.

## Interface
- MEM_BYTES, 128: memory size in bytes; legal word addresses are even and ≤ MEM_BYTES-2.
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Req0 / Req1  in  1  access request; held until the matching Gnt.
- We0 / We1  in  1  1 = write, 0 = read; valid with Req.
- Addr0 / Addr1  in  16  byte address.
- WData0 / WData1  in  16  write data.
- Gnt0 / Gnt1  out  1  one-cycle grant pulse; request fields captured at the same edge.
- Valid0 / Valid1  out  1  one-cycle completion pulse.
- Err0 / Err1  out  1  qualifies Valid: address illegal, access dropped.
- RData0 / RData1  out  16  read data; meaningful when Valid=1, We=0, Err=0.
- MemAddress  out  16  memory address.
- MemWriteData  out  16  memory write data.
- MemWrite  out  1  memory write enable.
- MemRead  out  1  memory read strobe.
- MemReadData  in  16  combinational read data from memory.

## Operation
- **Registers:** state, captured port id (`cur`), captured We/Addr/WData, error flag, round-robin pointer (`last`), response data.
- **IDLE:**
  - No request: stay in IDLE.
  - One port requesting: that port wins.
  - Both requesting: the winner is chosen per Configuration.
  - On a win: capture the winner's fields, set error = Addr[0] | (Addr > MEM_BYTES-2), assert Gnt of the winner for the cycle, then go to ACCESS.
- **ACCESS (1 cycle):**
  - MemAddress = captured Addr.
  - MemWrite = We & ~error & ~Reset.
  - MemRead = ~We & ~error.
  - MemWriteData = captured WData.
  - Capture MemReadData into response data at the closing edge. Response data is 0 when error is set or for writes.
  - Go to RESP.
- **RESP (1 cycle):** assert Valid/Err/RData on port `cur` only, update `last` = `cur`, go to IDLE.
- **Memory outputs outside ACCESS:** MemWrite = MemRead = 0, MemAddress = 0, MemWriteData = 0.
- **Non-winning port:** its request stays pending. It must keep Req and its fields stable and is served in the following IDLE.
- **Port 1 with error:** the bad access is dropped and never corrupts memory. MEM_BYTES-1 is not a legal address, so no access wraps past the end.

## Timing
- **Reset:** state = IDLE, `last` = 1, so port 0 wins the first tie. All Gnt, Valid, Err, RData, Mem* outputs are 0.
- **Gnt:** asserted in the cycle after Req is sampled high in IDLE.
- **Latency:** the request edge in IDLE is T. Gnt and ACCESS are in cycle T+1. The memory write commits at the end of T+1. Valid/RData are in cycle T+2. The next request can be sampled at the end of T+3, the IDLE cycle.
- **Throughput:** one access per 3 cycles.
- **Requester release:** the requester may drop Req in the cycle after Gnt. If Req stays high after Valid, it is treated as a new request.
- **Reset mid-operation:**
  - Reset during ACCESS gates MemWrite low in that cycle, so no partial write commits.
  - Reset in any state returns to IDLE next edge, with no Valid for the aborted access.
- **Simultaneous Req with Reset:** Reset wins; nothing is granted.

## Configuration
- **DMEM_ARB_RR_EN defined:** on simultaneous requests, the port ≠ `last` wins (round-robin). Starvation is bounded to one access.
- **Undefined:** fixed priority, port 0 always wins ties. `last` is still maintained but not used for arbitration.

## Structure
- **Shared package dmem_pkg:**
  - MEM_BYTES.
  - State enum {IDLE, ACCESS, RESP}.
  - Port-id constants PORT_CPU=0, PORT_DBG=1.
  - Address-legality function.
- **One sub-module, dmem_arb_pick:** combinational winner selection from Req0, Req1, `last` and the macro. It contains no state.

## Test plan
- Port 0 write Addr=2, WData=16'h1234, then port 0 read Addr=2 → Gnt0 at T+1, MemWrite=1 only in ACCESS, read Valid0 with RData0=16'h1234, memory bytes 2/3 = 12/34.
- Req0 and Req1 both reads in the same cycle, held → with DMEM_ARB_RR_EN, grants alternate 0,1,0,1 over 4 accesses. Without the macro, port 0 is served continuously while it requests.
- Port 1 write Addr=3 (odd), and separately Addr=127 → Valid1=1, Err1=1, MemWrite never asserted, memory unchanged.
- Port 1 write Addr=126, WData=16'hBEEF, then read Addr=126 → RData1=16'hBEEF, Err1=0 (last legal word).
- Reset asserted in the ACCESS cycle of a port 0 write Addr=4, WData=16'hFFFF → MemWrite=0, memory bytes 4/5 unchanged, no Valid0, all outputs 0 next cycle.
- Back-to-back: Req0 held through Valid0 → the second Gnt0 occurs exactly 3 cycles after the first.
